// File: rtl/mcu_clock_scheduler.sv
// Clock-enable scheduler for the multicycle MCU: HALT / RUN (programmable divisor) / STEP.
// Optional MCU_CE_COUNTER_EN adds a 32-bit ce_count output counting issued ce pulses.
module mcu_clock_scheduler #(
  parameter int          DIV_WIDTH = 16,
  parameter int unsigned RESET_DIV = 50000
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [1:0]           mode,
  input  logic                 div_wr,
  input  logic [DIV_WIDTH-1:0] div_in,
  input  logic                 step_req,
  output logic                 ce,
  output logic                 sclk,
  output logic [1:0]           state
`ifdef MCU_CE_COUNTER_EN
  ,
  output logic [31:0]          ce_count
`endif
);

  typedef enum logic [1:0] {
    ST_HALT = 2'b00,
    ST_RUN  = 2'b01,
    ST_STEP = 2'b10
  } state_t;

  state_t               state_reg, state_next;
  logic [DIV_WIDTH-1:0] cnt_reg, cnt_next;
  logic [DIV_WIDTH-1:0] div_q_reg;
  logic [DIV_WIDTH-1:0] div_eff;
  logic                 ce_reg, ce_next;
  logic                 sclk_reg;
  logic                 step_d_reg;

  // A zero divisor behaves as 1, so the period can never wrap through 2^DIV_WIDTH.
  assign div_eff = (div_q_reg == '0) ? DIV_WIDTH'(1) : div_q_reg;

  always_comb begin
    state_next = ST_HALT;
    cnt_next   = '0;
    ce_next    = 1'b0;

    case (mode)
      2'b01:   state_next = ST_RUN;
      2'b10:   state_next = ST_STEP;
      default: state_next = ST_HALT;
    endcase

    case (state_reg)
      ST_RUN: begin
        // >= rather than == so a divisor shrunk below cnt fires at once.
        if (cnt_reg >= div_eff - DIV_WIDTH'(1)) begin
          ce_next = 1'b1;
        end else begin
          cnt_next = cnt_reg + DIV_WIDTH'(1);
        end
      end
      ST_STEP: ce_next = step_req & ~step_d_reg;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= ST_HALT;
      cnt_reg    <= '0;
      div_q_reg  <= DIV_WIDTH'(RESET_DIV);
      ce_reg     <= 1'b0;
      sclk_reg   <= 1'b0;
      step_d_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      ce_reg     <= ce_next;
      sclk_reg   <= sclk_reg ^ ce_next;
      step_d_reg <= step_req;
      if (div_wr) begin
        div_q_reg <= div_in;
      end
    end
  end

  assign ce    = ce_reg;
  assign sclk  = sclk_reg;
  assign state = state_reg;

`ifdef MCU_CE_COUNTER_EN
  logic [31:0] ce_count_reg;

  always_ff @(posedge clk) begin
    if (reset) begin
      ce_count_reg <= '0;
    end else begin
      ce_count_reg <= ce_count_reg + 32'(ce_reg);
    end
  end

  assign ce_count = ce_count_reg;
`endif

endmodule

// File: tb/tb_mcu_clock_scheduler.sv
// Randomized and directed bench for mcu_clock_scheduler against a cycle-count reference model.
module tb_mcu_clock_scheduler;
  localparam int DW   = 16;
  localparam int RDIV = 12;

  logic          clk = 1'b0;
  logic          reset;
  logic [1:0]    mode;
  logic          div_wr;
  logic [DW-1:0] div_in;
  logic          step_req;
  logic          ce;
  logic          sclk;
  logic [1:0]    state;
`ifdef MCU_CE_COUNTER_EN
  logic [31:0]   ce_count;
`endif

  mcu_clock_scheduler #(.DIV_WIDTH(DW), .RESET_DIV(RDIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .mode     (mode),
    .div_wr   (div_wr),
    .div_in   (div_in),
    .step_req (step_req),
    .ce       (ce),
    .sclk     (sclk),
    .state    (state)
`ifdef MCU_CE_COUNTER_EN
    ,
    .ce_count (ce_count)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: elapsed cycles in the current RUN period, programmed period, last step level.
  int          m_state;
  int          m_elapsed;
  int          m_div;
  bit          m_prev_step;
  bit          m_ce;
  bit          m_sclk;
  logic [31:0] m_count;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_step();
    int  period;
    bit  pulse;
    if (reset) begin
      m_state = 0; m_elapsed = 0; m_div = RDIV; m_prev_step = 0;
      m_ce = 0; m_sclk = 0; m_count = 0;
    end else begin
      period = (m_div == 0) ? 1 : m_div;
      pulse  = 0;
      if (m_state == 1) begin
        m_elapsed++;
        if (m_elapsed >= period) begin
          pulse = 1;
          m_elapsed = 0;
        end
      end else begin
        m_elapsed = 0;
        pulse = (m_state == 2) && step_req && !m_prev_step;
      end
      m_count     = m_count + 32'(m_ce);
      m_ce        = pulse;
      m_sclk      = m_sclk ^ pulse;
      m_prev_step = step_req;
      if (div_wr) m_div = int'(div_in);
      m_state = (mode == 2'b11) ? 0 : int'(mode);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_val("model_ce", ce, m_ce);
    check_val("model_sclk", sclk, m_sclk);
    check_val("model_state", state, m_state);
`ifdef MCU_CE_COUNTER_EN
    check_val("model_ce_count", ce_count, m_count);
`endif
  endtask

  initial begin
    bit prev_sclk;
    reset = 1'b1; mode = 2'b00; div_wr = 1'b0; div_in = '0; step_req = 1'b0;
    tick();
    check_val("reset_ce", ce, 0);
    check_val("reset_sclk", sclk, 0);
    check_val("reset_state", state, 0);
    reset = 1'b0;

    // RUN with divisor 4: ce on cycles 4, 8, 12 after entry.
    div_wr = 1'b1; div_in = 4; tick(); div_wr = 1'b0;
    mode = 2'b01; tick();
    for (int k = 1; k <= 12; k++) begin
      tick();
      check_val("run4_ce", ce, (k % 4) == 0);
      check_val("run4_sclk", sclk, (k / 4) % 2);
    end
    $display("run div=4 done: checks=%0d errors=%0d", checks, errors);

    // Divisor 0 behaves as 1: ce every cycle.
    div_wr = 1'b1; div_in = 0; tick(); div_wr = 1'b0;
    tick();
    for (int k = 0; k < 6; k++) begin
      prev_sclk = sclk;
      tick();
      check_val("div0_ce", ce, 1);
      check_val("div0_sclk", sclk, !prev_sclk);
    end
    $display("run div=0 done: checks=%0d errors=%0d", checks, errors);

    // Divisor 10, shrink to 3 while cnt is 7.
    div_wr = 1'b1; div_in = 10; tick(); div_wr = 1'b0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (ce) break;
    end
    check_val("div10_ce_seen", ce, 1);
    repeat (7) tick();
    div_wr = 1'b1; div_in = 3; tick(); div_wr = 1'b0;
    tick(); check_val("shrink_ce0", ce, 1);
    tick(); check_val("shrink_ce1", ce, 0);
    tick(); check_val("shrink_ce2", ce, 0);
    tick(); check_val("shrink_ce3", ce, 1);
    $display("divisor shrink done: checks=%0d errors=%0d", checks, errors);

    // STEP: held level gives one pulse, a second edge gives one more.
    mode = 2'b10; step_req = 1'b0; tick(); tick();
    step_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      check_val("step_hold_ce", ce, i == 0);
    end
    step_req = 1'b0;
    repeat (3) begin
      tick();
      check_val("step_low_ce", ce, 0);
    end
    step_req = 1'b1;
    tick(); check_val("step_edge2_ce", ce, 1);
    tick(); check_val("step_edge2_after", ce, 0);
    step_req = 1'b0;
    $display("step sequence done: checks=%0d errors=%0d", checks, errors);

    // Reset mid-period restores RESET_DIV.
    mode = 2'b01; div_wr = 1'b1; div_in = 8; tick(); div_wr = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ce) break;
    end
    check_val("div8_ce_seen", ce, 1);
    repeat (5) tick();
    reset = 1'b1; tick(); reset = 1'b0;
    check_val("midreset_ce", ce, 0);
    check_val("midreset_state", state, 0);
    check_val("midreset_sclk", sclk, 0);
    tick();
    for (int k = 1; k <= RDIV; k++) begin
      tick();
      check_val("reset_div_ce", ce, k == RDIV);
    end
    $display("mid-period reset done: checks=%0d errors=%0d", checks, errors);

`ifdef MCU_CE_COUNTER_EN
    reset = 1'b1; tick(); reset = 1'b0;
    mode = 2'b10; tick();
    repeat (5) begin
      step_req = 1'b1; tick();
      step_req = 1'b0; tick(); tick();
    end
    check_val("ce_count_5", ce_count, 5);
    step_req = 1'b1;
    force dut.ce_count_reg = 32'hFFFF_FFFF;
    m_count = 32'hFFFF_FFFF;
    tick();
    release dut.ce_count_reg;
    step_req = 1'b0;
    tick();
    check_val("ce_count_wrap", ce_count, 0);
    $display("ce counter done: checks=%0d errors=%0d", checks, errors);
`endif

    // Randomized phase.
    for (int i = 0; i < 3000; i++) begin
      reset  = ($urandom_range(0, 299) == 0);
      div_wr = ($urandom_range(0, 19) == 0);
      div_in = DW'($urandom_range(0, 9));
      if ($urandom_range(0, 15) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) step_req = ~step_req;
      tick();
    end
    reset = 1'b0; div_wr = 1'b0;
    $display("random phase done: checks=%0d errors=%0d", checks, errors);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
